muldiv_hilo_unit: RTL

//  Execute-stage consumer of the ALU decoder's {alucontrol, hien, loen} word for MULT/DIV.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_core.sv | 45 ++++
 rtl/muldiv_hilo_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared ALU codes and FSM state type for the iterative MULT/DIV unit that owns HI/LO.
package muldiv_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iteration datapath: one shift-add (multiply) or shift-subtract (divide) step per cycle.
// The 2*WIDTH accumulator holds {partial product} or {remainder, quotient/dividend}.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_div,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic               w_fits;

  // Multiply: conditionally add multiplicand to the upper half, then shift right.
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};

  // Divide: trial-subtract the divisor from {remainder, next dividend bit}.
  assign {w_borrow, w_diff} = {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {2'b00, r_b};
  assign w_fits = ~(w_borrow | w_diff[WIDTH]);

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
      r_b   <= i_div ? i_b : i_a;
    end else if (i_step) begin
      if (!i_div)
        r_acc <= {w_add, r_acc[WIDTH-1:1]};
      else if (w_fits)
        r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Execute-stage MULT/DIV unit: FSM, iteration counter, sign capture and fix-up, and the
// architectural HI/LO registers. Stalls the pipeline (busy) for WIDTH+1 cycles per operation.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       alucontrol,
  input  logic             hien,
  input  logic             loen,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t      r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_div, r_sign_a, r_sign_b, r_dbz;
  logic [WIDTH-1:0]   r_srca;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;
  logic               w_accept, w_load, w_step, w_write;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic c, input logic [2*WIDTH-1:0] x);
    return c ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] x);
    return c ? -x : x;
  endfunction

  assign w_accept = start & hien & loen & ~flush & (r_state == IDLE) &
                    ((alucontrol == ALU_MULT) | (alucontrol == ALU_DIV));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (flush) w_next = IDLE;
               else if (r_cnt == CNT_LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    w_load  = w_accept;
    w_step  = (r_state == RUN) & ~flush;
    w_write = (r_state == FIX) & ~flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_step)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_div <= (alucontrol == ALU_DIV);
      r_sign_a <= srca[WIDTH-1];
      r_sign_b <= srcb[WIDTH-1];
      r_dbz    <= (srcb == '0);
      r_srca   <= srca;
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (alucontrol == ALU_DIV),
    .i_a    (mag(srca)),
    .i_b    (mag(srcb)),
    .o_acc  (w_acc)
  );

  // Sign fix-up during FIX; divide-by-zero bypasses the iterated result.
  always_comb begin
    {w_hi_fix, w_lo_fix} = neg2_if(r_sign_a ^ r_sign_b, w_acc);
    if (r_op_div) begin
      if (r_dbz) begin
        w_hi_fix = r_srca;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = neg_if(r_sign_a, w_acc[2*WIDTH-1:WIDTH]);
        w_lo_fix = neg_if(r_sign_a ^ r_sign_b, w_acc[WIDTH-1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_write) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

  // The hazard unit stalls the execute stage while busy, so start never coincides with it.
  a_no_start_when_busy: assert property (@(posedge clk) disable iff (!reset_n) !(start && busy));

endmodule
